// File: rtl/cipher_seq_ctrl_pkg.sv
// Shared constants for the receive -> decrypt -> display/echo sequencer.
// State encodings are plain 3-bit constants so older tooling can reuse them.
package cipher_seq_ctrl_pkg;

    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DISP_W     = 32;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_WAIT      = 3'd2;
    localparam logic [2:0] ST_CAPTURE   = 3'd3;
    localparam logic [2:0] ST_SEND      = 3'd4;
    localparam logic [2:0] ST_SEND_WAIT = 3'd5;

endpackage

// File: rtl/cipher_seq_ctrl.sv
// Sequences one ciphertext frame at a time through a fixed-latency decrypt core,
// latches the plaintext for the display and optionally echoes it over the UART.
module cipher_seq_ctrl
    import cipher_seq_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned DEC_LATENCY = 16,
    parameter bit          ENABLE_TX   = 1'b1,
    parameter int unsigned BUSY_GUARD  = 4
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic              recv_done,
    input  logic [DATA_W-1:0] recv_data,
    output logic [DATA_W-1:0] dec_in,
    input  logic [DATA_W-1:0] dec_result,
    output logic [DISP_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              send_en,
    output logic [DATA_W-1:0] send_data,
    input  logic              send_busy,
    output logic              overrun,
    output logic [15:0]       frame_cnt,
    output logic              busy
);

    localparam int unsigned WCNT_W = (DEC_LATENCY > 1) ? $clog2(DEC_LATENCY) : 1;
    localparam int unsigned GCNT_W = (BUSY_GUARD > 1) ? $clog2(BUSY_GUARD) : 1;

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic              pend_valid_q, pend_valid_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic              seen_busy_q, seen_busy_d;
    logic [DATA_W-1:0] plain_q, plain_d;
    logic [DATA_W-1:0] dec_in_q, dec_in_d;
    logic [DISP_W-1:0] disp_data_q, disp_data_d;
    logic              disp_valid_q, disp_valid_d;
    logic              send_en_q, send_en_d;
    logic [DATA_W-1:0] send_data_q, send_data_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              consume;

    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d      = state_q;
        pend_data_d  = pend_data_q;
        pend_valid_d = pend_valid_q;
        wcnt_d       = wcnt_q;
        gcnt_d       = gcnt_q;
        seen_busy_d  = seen_busy_q;
        plain_d      = plain_q;
        dec_in_d     = dec_in_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        send_en_d    = 1'b0;
        send_data_d  = send_data_q;
        overrun_d    = overrun_q;
        frame_cnt_d  = frame_cnt_q;
        consume      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                dec_in_d = pend_data_q;
                consume  = 1'b1;
                wcnt_d   = WCNT_W'(DEC_LATENCY - 1);
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt_q == '0) state_d = ST_CAPTURE;
                else              wcnt_d  = wcnt_q - WCNT_W'(1);
            end
            ST_CAPTURE: begin
                plain_d      = dec_result;
                disp_data_d  = dec_result[DISP_W-1:0];
                disp_valid_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 16'd1;
                state_d      = ENABLE_TX ? ST_SEND : ST_IDLE;
            end
            ST_SEND: begin
                if (!send_busy) begin
                    send_en_d   = 1'b1;
                    send_data_d = plain_q;
                    gcnt_d      = GCNT_W'(BUSY_GUARD - 1);
                    seen_busy_d = 1'b0;
                    state_d     = ST_SEND_WAIT;
                end
            end
            ST_SEND_WAIT: begin
                // Give up if the transmitter never acknowledges, otherwise wait for its fall.
                if (!seen_busy_q) begin
                    if (send_busy)          seen_busy_d = 1'b1;
                    else if (gcnt_q == '0)  state_d     = ST_IDLE;
                    else                    gcnt_d      = gcnt_q - GCNT_W'(1);
                end else if (!send_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A frame landing in the consuming clock refills the slot instead of overrunning.
        if (recv_done) begin
            pend_data_d  = recv_data;
            pend_valid_d = 1'b1;
            if (pend_valid_q && !consume) overrun_d = 1'b1;
        end else if (consume) begin
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q      <= ST_IDLE;
            pend_data_q  <= '0;
            pend_valid_q <= 1'b0;
            wcnt_q       <= '0;
            gcnt_q       <= '0;
            seen_busy_q  <= 1'b0;
            plain_q      <= '0;
            dec_in_q     <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            send_en_q    <= 1'b0;
            send_data_q  <= '0;
            overrun_q    <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q      <= state_d;
            pend_data_q  <= pend_data_d;
            pend_valid_q <= pend_valid_d;
            wcnt_q       <= wcnt_d;
            gcnt_q       <= gcnt_d;
            seen_busy_q  <= seen_busy_d;
            plain_q      <= plain_d;
            dec_in_q     <= dec_in_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            send_en_q    <= send_en_d;
            send_data_q  <= send_data_d;
            overrun_q    <= overrun_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign dec_in     = dec_in_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign send_en    = send_en_q;
    assign send_data  = send_data_q;
    assign overrun    = overrun_q;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cipher_seq_ctrl.sv
// Self-checking bench: model decrypt core and transmitter, directed vectors,
// multi-cycle corner sequences and a randomized run against a schedule model.
module tb_cipher_seq_ctrl;

    localparam int          L      = 16;
    localparam int          G      = 4;
    localparam int          H_RAND = 3;
    localparam int          P      = L + H_RAND + 6;  // LOAD-to-LOAD spacing when back to back
    localparam logic [63:0] KEY    = 64'hA5A5_A5A5_A5A5_A5A5;

    typedef struct {
        logic [63:0] data;
        logic [31:0] exp_disp;
        logic [15:0] exp_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        recv_done = 1'b0;
    logic [63:0] recv_data = '0;
    logic [63:0] dec_in, dec_result, send_data;
    logic [31:0] disp_data;
    logic        disp_valid, send_en, send_busy, overrun, busy;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_hold = 10;
    int busy_left = 0;
    int sends = 0;
    logic [15:0] last_cnt = '0;
    logic [31:0] obs[$];
    int          arr_q[$];
    logic [63:0] dat_q[$];
    logic [31:0] exp_q[$];
    bit          exp_ovr;
    logic [63:0] pipe[L];

    cipher_seq_ctrl #(
        .DATA_W(64), .DEC_LATENCY(L), .ENABLE_TX(1'b1), .BUSY_GUARD(G)
    ) dut (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n),
        .recv_done(recv_done), .recv_data(recv_data),
        .dec_in(dec_in), .dec_result(dec_result),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .send_en(send_en), .send_data(send_data), .send_busy(send_busy),
        .overrun(overrun), .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    initial foreach (pipe[i]) pipe[i] = '0;

    // Decrypt core model: XOR with a constant through an L-deep pipe.
    always @(posedge clk) begin
        pipe[0] <= dec_in ^ KEY;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign dec_result = pipe[L-1];

    // Transmitter model: busy for tx_hold clocks after seeing send_en (0 = never busy).
    always @(posedge clk) begin
        if (send_en && tx_hold > 0) busy_left <= tx_hold;
        else if (busy_left > 0)     busy_left <= busy_left - 1;
    end
    assign send_busy = (busy_left != 0);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && frame_cnt == last_cnt + 16'd1) obs.push_back(disp_data);
        last_cnt <= frame_cnt;
        if (send_en) sends <= sends + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_frame(input logic [63:0] d, output int arrival);
        recv_data = d;
        recv_done = 1'b1;
        tick();
        recv_done = 1'b0;
        arrival   = cyc;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    task automatic wait_cnt(input string name, input logic [15:0] target, input int budget);
        int n = 0;
        while (frame_cnt != target && n < budget) begin
            tick();
            n++;
        end
        check(name, frame_cnt, target);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        tick();
    endtask

    // Schedule model: a slot loads at max(first arrival + 2, previous load + P);
    // anything arriving before that load replaces the slot and flags an overrun.
    task automatic run_model();
        int          last_load = -100000;
        bit          has_pend = 1'b0;
        int          pend_first = 0;
        logic [63:0] pend_d = '0;
        int          lt;
        exp_q.delete();
        exp_ovr = 1'b0;
        foreach (arr_q[i]) begin
            if (has_pend) begin
                lt = (pend_first + 2 > last_load + P) ? pend_first + 2 : last_load + P;
                if (arr_q[i] < lt) begin
                    pend_d  = dat_q[i];
                    exp_ovr = 1'b1;
                end else begin
                    exp_q.push_back(32'(pend_d ^ KEY));
                    last_load  = lt;
                    pend_first = arr_q[i];
                    pend_d     = dat_q[i];
                end
            end else begin
                has_pend   = 1'b1;
                pend_first = arr_q[i];
                pend_d     = dat_q[i];
            end
        end
        if (has_pend) exp_q.push_back(32'(pend_d ^ KEY));
    endtask

    initial begin
        vec_t        vecs[4];
        int          a;
        int          s0;
        int          n;
        logic [63:0] fa, fb, fc;

        vecs[0] = '{64'h0123_4567_89AB_CDEF, 32'h2C0E_684A, 16'd1};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'h5A5A_5A5A, 16'd2};
        vecs[2] = '{64'h0000_0000_0000_0000, 32'hA5A5_A5A5, 16'd3};
        vecs[3] = '{64'hDEAD_BEEF_0BAD_F00D, 32'hAE08_55A8, 16'd4};

        // Reset state
        ticks(2);
        check("rst dec_in", dec_in, 0);
        check("rst disp_data", disp_data, 0);
        check("rst disp_valid", disp_valid, 0);
        check("rst send_en", send_en, 0);
        check("rst overrun", overrun, 0);
        check("rst frame_cnt", frame_cnt, 0);
        check("rst busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Directed vectors: exact latency, display, echo handshake
        foreach (vecs[i]) begin
            s0 = sends;
            send_frame(vecs[i].data, a);
            ticks(L + 2);
            check("early frame_cnt", frame_cnt, vecs[i].exp_cnt - 16'd1);
            check("early disp_valid", disp_valid, (i > 0) ? 1 : 0);
            tick();
            check("vec disp_data", disp_data, vecs[i].exp_disp);
            check("vec frame_cnt", frame_cnt, vecs[i].exp_cnt);
            check("vec disp_valid", disp_valid, 1'b1);
            check("vec dec_in", dec_in, vecs[i].data);
            n = 0;
            while (!send_busy && n < 20) begin tick(); n++; end
            check("tx busy rise", send_busy, 1'b1);
            n = 0;
            while (send_busy && n < 30) begin tick(); n++; end
            check("tx busy fall", send_busy, 1'b0);
            check("busy before drop", busy, 1'b1);
            tick();
            check("busy after drop", busy, 1'b0);
            check("one send_en", sends, s0 + 1);
            check("send_data", send_data, vecs[i].data ^ KEY);
        end

        // Two frames five clocks apart: both processed in order
        tx_hold = H_RAND;
        obs.delete();
        fa = 64'h1111_2222_3333_4444;
        fb = 64'h5555_6666_7777_8888;
        send_frame(fa, a);
        ticks(4);
        send_frame(fb, a);
        wait_cnt("pair cnt", 16'd6, 200);
        wait_idle("pair idle", 200);
        check("pair count", obs.size(), 2);
        if (obs.size() == 2) begin
            check("pair first", obs[0], 32'(fa ^ KEY));
            check("pair second", obs[1], 32'(fb ^ KEY));
        end
        check("pair overrun", overrun, 1'b0);

        // Second frame arrives in the LOAD clock of the first
        obs.delete();
        send_frame(fb, a);
        tick();
        send_frame(fa, a);
        wait_cnt("load-clk cnt", 16'd8, 200);
        wait_idle("load-clk idle", 200);
        check("load-clk count", obs.size(), 2);
        if (obs.size() == 2) begin
            check("load-clk first", obs[0], 32'(fb ^ KEY));
            check("load-clk second", obs[1], 32'(fa ^ KEY));
        end
        check("load-clk overrun", overrun, 1'b0);

        // Transmitter never responds: guard timeout
        tx_hold = 0;
        s0 = sends;
        send_frame(fa, a);
        n = 0;
        while (!send_en && n < L + 20) begin tick(); n++; end
        check("guard send_en", send_en, 1'b1);
        ticks(G - 1);
        check("guard busy held", busy, 1'b1);
        tick();
        check("guard busy drop", busy, 1'b0);
        check("guard sends", sends, s0 + 1);
        check("guard frame_cnt", frame_cnt, 16'd9);

        // Three frames in WAIT: middle one is overwritten
        tx_hold = H_RAND;
        obs.delete();
        fc = 64'h9999_AAAA_BBBB_CCCC;
        send_frame(fa, a);
        ticks(3);
        send_frame(fb, a);
        ticks(3);
        send_frame(fc, a);
        wait_cnt("triple cnt", 16'd11, 200);
        wait_idle("triple idle", 200);
        ticks(5);
        check("triple count", obs.size(), 2);
        if (obs.size() == 2) begin
            check("triple first", obs[0], 32'(fa ^ KEY));
            check("triple third", obs[1], 32'(fc ^ KEY));
        end
        check("triple overrun", overrun, 1'b1);

        // Reset in the middle of WAIT
        send_frame(fb, a);
        ticks(6);
        rst_n = 1'b0;
        #1;
        check("midrst dec_in", dec_in, 0);
        check("midrst disp_data", disp_data, 0);
        check("midrst disp_valid", disp_valid, 0);
        check("midrst send_data", send_data, 0);
        check("midrst overrun", overrun, 0);
        check("midrst frame_cnt", frame_cnt, 0);
        check("midrst busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(fc, a);
        ticks(L + 3);
        check("post-rst disp_data", disp_data, 32'(fc ^ KEY));
        check("post-rst frame_cnt", frame_cnt, 16'd1);
        wait_idle("post-rst idle", 200);

        // Frame counter wrap from a forced start
        force dut.frame_cnt_q = 16'hFFFF;
        tick();
        release dut.frame_cnt_q;
        tick();
        check("wrap start", frame_cnt, 16'hFFFF);
        send_frame(fa, a);
        ticks(L + 3);
        check("wrap frame_cnt", frame_cnt, 16'h0000);
        wait_idle("wrap idle", 200);

        // Randomized arrivals against the schedule model
        do_reset();
        obs.delete();
        arr_q.delete();
        dat_q.delete();
        for (int k = 0; k < 30; k++) begin
            ticks($urandom_range(0, 39));
            fa = {$urandom, $urandom};
            send_frame(fa, a);
            arr_q.push_back(a);
            dat_q.push_back(fa);
        end
        ticks(4 * P);
        wait_idle("rand idle", 200);
        run_model();
        check("rand count", obs.size(), exp_q.size());
        check("rand frame_cnt", frame_cnt, 16'(exp_q.size()));
        check("rand overrun", overrun, exp_ovr);
        foreach (exp_q[i]) begin
            if (i < obs.size()) check("rand plain", obs[i], exp_q[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
